conv_stream_driver: RTL and testbench
=====================================

Name: conv_stream_driver

Overview:
Host-side transmitter and reader for the 6-bit shift-in convolution/maxpool accelerator.
- Accepts 24-bit words (4 lanes x 6 bits) tagged as weight or input over a valid/ready handshake.
- Serializes each word into 4 consecutive beats on the accelerator's data/select pins.
- On request, waits for the accelerator pipeline to settle and captures its 14-bit running-max output, returning it on a valid/ready result channel.
- Sits between a test/host sequencer and the accelerator pins.

Parameters:
LANE_W, 6, bits per beat / per lane
LANES, 4, beats per word
ACC_W, 14, accelerator result width
SETTLE, 2, rising edges from the final-beat sampling edge to the result-capture edge

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s_valid  in  1  word request valid
s_ready  out  1  driver can accept a word
s_data  in  24  word; lane i = s_data[6i+5:6i]
s_is_weight  in  1  1 = weight word, 0 = input window
s_readback  in  1  capture the accelerator result after this word
drv_data  out  6  to accelerator ui_in[5:0]
drv_sel  out  1  to accelerator uio_in[7]; 1 = shift into weights
acc_lo  in  8  from accelerator uo_out (result[7:0])
acc_hi  in  6  from accelerator uio_out[5:0] (result[13:8])
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  14  captured result {acc_hi, acc_lo}
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values (any cycle with rst_n=0, FSM forced to IDLE, takes priority over everything):
  - s_ready=0 during reset, 1 in the first IDLE cycle after release
  - drv_data=0, drv_sel=0, m_valid=0, m_data=0, busy=0
  - all counters 0
- The accelerator shifts on every rising edge. The driver therefore always drives a defined beat.
- Idle beat: drv_sel=0, drv_data=0. This shifts zeros into the accelerator's inputs only; weights are untouched.
- FSM states:
  - IDLE: s_ready=1. Handshake on s_valid&s_ready latches s_data, s_is_weight and s_readback, then goes to SHIFT with beat=0. Drives idle beat.
  - SHIFT: drv_data = lane[beat], drv_sel = latched s_is_weight. Order is lane0 first, lane3 last, so after 4 edges the accelerator register equals s_data exactly. beat increments each cycle. After beat==LANES-1: go to SETTLE with cnt=0 if readback is set, else back to IDLE.
  - SETTLE: drives idle beat. cnt counts rising edges after the final-beat edge. On the SETTLE-th edge, latch m_data={acc_hi,acc_lo} and go to RESP.
  - RESP: m_valid=1 and m_data held stable; drives idle beat. On m_valid&m_ready go to IDLE with m_valid=0 next cycle.
- Beats within a word are strictly contiguous: no idle beat may be inserted between lanes, because a gap would misalign the window.
- Back-to-back words: at least one idle beat (the IDLE cycle) separates words. This is legal because the idle beat writes only zeros into the inputs register.
- s_ready=0 in SHIFT, SETTLE and RESP. s_valid held during those states is not consumed. The latched word is immune to s_data changes after the handshake.
- m_ready asserted outside RESP is ignored.
- Reset mid-operation (any state): immediate return to IDLE, partial word abandoned, pending result dropped (m_valid=0).
- Capture is a plain sample. The driver performs no comparison; max semantics belong to the accelerator.

Decomposition:
- Shared package conv_pkg holds:
  - LANE_W, LANES, ACC_W
  - the state enum {IDLE, SHIFT, SETTLE, RESP}
  - the SEL_WEIGHT=1 / SEL_INPUT=0 constants
- The accelerator RTL imports the same width constants.
- One natural sub-module, lane_serializer: 24-bit load, 6-bit beat output, 2-bit beat counter, last-beat flag.
- FSM and capture logic live in the top.

Test Plan:
- Beat order: handshake s_data=24'hFC0FC0, s_is_weight=1 -> drv_data beats 0,63,0,63 on 4 consecutive cycles with drv_sel=1; then idle beat (0, sel 0); s_ready low for exactly those 4 cycles.
- Full job against accelerator model: weights 24'h041041 (all lanes 1), then input 24'h041041 with s_readback=1 -> m_valid after 4+SETTLE cycles, m_data=14'd4.
- Max width: weights and input 24'hFFFFFF with readback -> m_data=14'd15876 (14'h3E04), no truncation.
- Backpressure: hold m_ready=0 for 10 cycles in RESP -> m_valid and m_data stable; s_ready=0; drv_sel=0 and drv_data=0 throughout; one cycle after m_ready=1, m_valid=0 and s_ready=1.
- Reset mid-SHIFT: assert rst_n=0 at beat 2 -> next edge drv_data=0, drv_sel=0, m_valid=0; after release s_ready=1 and a fresh word serializes from lane0.
- No readback: input word with s_readback=0 -> returns to IDLE right after beat 3, m_valid never asserts, next word accepted one cycle later.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, FSM states and request bundle for the
// conv accelerator host-side stream driver.
package conv_pkg;

    localparam int LANE_W   = 6;
    localparam int LANES    = 4;
    localparam int WORD_W   = LANE_W * LANES;
    localparam int BEAT_W   = $clog2(LANES);
    localparam int ACC_W    = 14;
    localparam int ACC_LO_W = 8;
    localparam int ACC_HI_W = ACC_W - ACC_LO_W;

    localparam logic SEL_WEIGHT = 1'b1;
    localparam logic SEL_INPUT  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              is_weight;
        logic              readback;
    } req_t;

endpackage

// File: rtl/lane_serializer.sv
// Splits a 24-bit word into 6-bit beats, lane0 first.
// The shift register drains to zero, which doubles as the idle beat.
module lane_serializer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic [LANE_W-1:0] beat_data,
    output logic              last
);

    logic [WORD_W-1:0] sr;
    logic [BEAT_W-1:0] beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr   <= '0;
            beat <= '0;
        end else if (load) begin
            sr   <= word;
            beat <= '0;
        end else if (shift) begin
            sr   <= sr >> LANE_W;
            beat <= beat + 1'b1;
        end
    end

    assign beat_data = sr[LANE_W-1:0];
    assign last      = (beat == BEAT_W'(LANES - 1));

endmodule

// File: rtl/conv_stream_driver.sv
// Host driver: serializes tagged words onto the accelerator pins
// and captures its running-max result on request.
module conv_stream_driver
    import conv_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_is_weight,
    input  logic                s_readback,
    output logic [LANE_W-1:0]   drv_data,
    output logic                drv_sel,
    input  logic [ACC_LO_W-1:0] acc_lo,
    input  logic [ACC_HI_W-1:0] acc_hi,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [ACC_W-1:0]    m_data,
    output logic                busy
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t           state;
    req_t             req;
    logic             readback_q;
    logic [CNT_W-1:0] cnt;
    logic             take;
    logic             last;
    logic             shifting;

    assign req = '{
        data:      s_data,
        is_weight: s_is_weight,
        readback:  s_readback
    };

    assign take     = (state == S_IDLE) && s_valid && s_ready;
    assign shifting = (state == S_SHIFT);

    lane_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (take),
        .shift     (shifting),
        .word      (req.data),
        .beat_data (drv_data),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            readback_q <= 1'b0;
            cnt        <= '0;
            s_ready    <= 1'b0;
            drv_sel    <= SEL_INPUT;
            m_valid    <= 1'b0;
            m_data     <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        state      <= S_SHIFT;
                        readback_q <= req.readback;
                        drv_sel    <= req.is_weight ? SEL_WEIGHT
                                                    : SEL_INPUT;
                        s_ready    <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Beats stay contiguous; leave only after lane3.
                    if (last) begin
                        drv_sel <= SEL_INPUT;
                        cnt     <= '0;
                        if (readback_q) begin
                            state <= S_SETTLE;
                        end else begin
                            state   <= S_IDLE;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        m_data  <= {acc_hi, acc_lo};
                        m_valid <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver with a small
// shift-in dot-product / running-max accelerator model.
module tb_conv_stream_driver;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_is_weight = 1'b0;
    logic        s_readback = 1'b0;
    logic [5:0]  drv_data;
    logic        drv_sel;
    logic [7:0]  acc_lo;
    logic [5:0]  acc_hi;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [13:0] m_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_stream_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_is_weight (s_is_weight),
        .s_readback  (s_readback),
        .drv_data    (drv_data),
        .drv_sel     (drv_sel),
        .acc_lo      (acc_lo),
        .acc_hi      (acc_hi),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
    );

    // Accelerator: shifts every edge, running max of the window dot product.
    logic [23:0] w_q;
    logic [23:0] i_q;
    logic [13:0] max_q;

    function automatic logic [13:0] dot(input logic [23:0] w,
                                        input logic [23:0] x);
        logic [13:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            s = s + 14'(w[6*k +: 6]) * 14'(x[6*k +: 6]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            w_q   <= '0;
            i_q   <= '0;
            max_q <= '0;
        end else begin
            if (drv_sel) w_q <= {drv_data, w_q[23:6]};
            else         i_q <= {drv_data, i_q[23:6]};
            if (dot(w_q, i_q) > max_q) max_q <= dot(w_q, i_q);
        end
    end

    assign acc_lo = max_q[7:0];
    assign acc_hi = max_q[13:8];

    typedef struct {
        logic [23:0] data;
        logic        wt;
        logic        rb;
        logic [5:0]  b [4];
        logic [13:0] res;
    } vec_t;

    function automatic vec_t mk(input logic [23:0] d,
                                input logic wt, input logic rb,
                                input logic [5:0] b0, input logic [5:0] b1,
                                input logic [5:0] b2, input logic [5:0] b3,
                                input logic [13:0] res);
        vec_t v;
        v.data = d;
        v.wt   = wt;
        v.rb   = rb;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.res  = res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " s_ready wait"}, 32'(s_ready), 32'd1);
    endtask

    // Returns at the negedge where beat0 is on the pins.
    task automatic start_word(input logic [23:0] d, input logic wt,
                              input logic rb, input string tag);
        wait_ready(tag);
        s_valid     = 1'b1;
        s_data      = d;
        s_is_weight = wt;
        s_readback  = rb;
        @(negedge clk);
        s_valid     = 1'b0;
        s_data      = ~d;
        s_is_weight = ~wt;
        s_readback  = ~rb;
    endtask

    task automatic apply(input vec_t v, input string tag);
        start_word(v.data, v.wt, v.rb, tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s b%0d data", tag, k),
                32'(drv_data), 32'(v.b[k]));
            chk($sformatf("%s b%0d sel", tag, k),
                32'(drv_sel), 32'(v.wt));
            chk($sformatf("%s b%0d s_ready", tag, k),
                32'(s_ready), 32'd0);
            chk($sformatf("%s b%0d busy", tag, k), 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk({tag, " idle data"}, 32'(drv_data), 32'd0);
        chk({tag, " idle sel"}, 32'(drv_sel), 32'd0);
        chk({tag, " m_valid n4"}, 32'(m_valid), 32'd0);
        if (!v.rb) begin
            chk({tag, " s_ready n4"}, 32'(s_ready), 32'd1);
            chk({tag, " busy n4"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, " s_ready n4"}, 32'(s_ready), 32'd0);
            @(negedge clk);
            chk({tag, " m_valid n5"}, 32'(m_valid), 32'd0);
            @(negedge clk);
            chk({tag, " m_valid n6"}, 32'(m_valid), 32'd1);
            chk({tag, " m_data"}, 32'(m_data), 32'(v.res));
            chk({tag, " s_ready resp"}, 32'(s_ready), 32'd0);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            chk({tag, " m_valid done"}, 32'(m_valid), 32'd0);
            chk({tag, " s_ready done"}, 32'(s_ready), 32'd1);
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = mk(24'hFC0FC0, 1, 0, 0, 63, 0, 63, 0);
        tbl[1] = mk(24'h041041, 1, 0, 1, 1, 1, 1, 0);
        tbl[2] = mk(24'h041041, 0, 1, 1, 1, 1, 1, 14'd4);
        tbl[3] = mk(24'hFFFFFF, 1, 0, 63, 63, 63, 63, 0);
        tbl[4] = mk(24'hFFFFFF, 0, 1, 63, 63, 63, 63, 14'd15876);
        tbl[5] = mk(24'h123456, 0, 0, 22, 17, 35, 4, 0);

        repeat (3) @(negedge clk);
        chk("rst s_ready", 32'(s_ready), 32'd0);
        chk("rst drv_data", 32'(drv_data), 32'd0);
        chk("rst drv_sel", 32'(drv_sel), 32'd0);
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst s_ready", 32'(s_ready), 32'd1);

        for (int i = 0; i < 6; i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Backpressure with s_valid held while busy.
        start_word(24'hFFFFFF, 0, 1, "bp");
        s_valid = 1'b1;
        s_data  = 24'h0;
        begin
            int n;
            n = 0;
            while (m_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp m_valid", 32'(m_valid), 32'd1);
            chk("bp m_data", 32'(m_data), 32'd15876);
            chk("bp s_ready", 32'(s_ready), 32'd0);
            chk("bp drv_sel", 32'(drv_sel), 32'd0);
            chk("bp drv_data", 32'(drv_data), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp m_valid done", 32'(m_valid), 32'd0);
        chk("bp s_ready done", 32'(s_ready), 32'd1);

        // Reset while beat2 is on the pins.
        start_word(24'hFFFFFF, 1, 1, "rs");
        @(negedge clk);
        @(negedge clk);
        chk("rs beat2", 32'(drv_data), 32'd63);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs drv_data", 32'(drv_data), 32'd0);
        chk("rs drv_sel", 32'(drv_sel), 32'd0);
        chk("rs m_valid", 32'(m_valid), 32'd0);
        chk("rs busy", 32'(busy), 32'd0);
        chk("rs s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs s_ready rel", 32'(s_ready), 32'd1);
        apply(mk(24'h123456, 1, 0, 22, 17, 35, 4, 0), "rs_w");
        apply(mk(24'h041041, 0, 1, 1, 1, 1, 1, 14'd78), "rs_i");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
